// File: rtl/vga_text_writer.sv
// Text-console sequencer: turns a byte stream into tile-register writes (cs/odata) for the 20x15 display.
// Latency: one cycle from accept to write. Backpressure: char_ready drops during clears and row blanking.
// Optional TEXTWR_ROWCLR_EN: blank the wrapped-into row on line wrap / newline.
module vga_text_writer #(
    parameter int         COLS        = 20,
    parameter int         ROWS        = 15,
    parameter logic [5:0] BLANK_GLYPH = 6'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [7:0]  char_code,
    input  logic [11:0] char_color,
    input  logic        clear_req,
    output logic        cs,
    output logic [31:0] odata,
    output logic        busy,
    output logic [8:0]  cursor
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int TOTAL = COLS * ROWS;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR_ALL
`ifdef TEXTWR_ROWCLR_EN
        , CLR_ROW
`endif
    } state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [8:0]    cnt;

    logic [RW-1:0] row_next;
    logic [8:0]    row_base;
    logic [5:0]    glyph;
    logic          is_print;
    logic          accept;
    logic          start_clear;
`ifdef TEXTWR_ROWCLR_EN
    logic [8:0]    next_base;
    assign next_base = 9'(row_next) * 9'(COLS);
`endif

    function automatic logic [31:0] pack_word(input logic [11:0] color,
                                              input logic [8:0]  idx,
                                              input logic [5:0]  g);
        return {color, 3'b000, idx, 2'b00, g};
    endfunction

    assign row_next    = (row == LAST_ROW) ? '0 : row + 1'b1;
    assign row_base    = 9'(row) * 9'(COLS);
    assign cursor      = row_base + 9'(col);
    assign busy        = (state != IDLE);
    assign char_ready  = (state == IDLE) && !clear_req;
    assign accept      = char_valid && char_ready;
    assign is_print    = (char_code >= 8'h20) && (char_code <= 8'h7F);
    assign glyph       = 6'(char_code - 8'h20);
    // Form feed behaves exactly like an external clear request.
    assign start_clear = clear_req || (accept && char_code == 8'h0C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            cnt   <= '0;
            cs    <= 1'b0;
            odata <= '0;
        end else begin
            cs    <= 1'b0;
            odata <= '0;
            case (state)
                IDLE: begin
                    if (start_clear) begin
                        // First clear write issues here so the sweep lands on N+1..N+TOTAL.
                        row   <= '0;
                        col   <= '0;
                        cs    <= 1'b1;
                        odata <= pack_word(12'h000, 9'd0, BLANK_GLYPH);
                        cnt   <= 9'd1;
                        state <= CLR_ALL;
                    end else if (accept) begin
                        if (is_print) begin
                            cs    <= 1'b1;
                            odata <= pack_word(char_color, cursor, glyph);
                            if (col == LAST_COL) begin
                                col <= '0;
                                row <= row_next;
`ifdef TEXTWR_ROWCLR_EN
                                cnt   <= 9'd0;
                                state <= CLR_ROW;
`endif
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            case (char_code)
                                8'h0A: begin
                                    col <= '0;
                                    row <= row_next;
`ifdef TEXTWR_ROWCLR_EN
                                    cs    <= 1'b1;
                                    odata <= pack_word(12'h000, next_base, BLANK_GLYPH);
                                    cnt   <= 9'd1;
                                    state <= CLR_ROW;
`endif
                                end
                                8'h0D: col <= '0;
                                8'h08: begin
                                    if (col != '0) begin
                                        col   <= col - 1'b1;
                                        cs    <= 1'b1;
                                        odata <= pack_word(12'h000, cursor - 9'd1, BLANK_GLYPH);
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_ALL: begin
                    // One idle cycle after the last write keeps char_ready low until it has landed.
                    if (cnt == 9'(TOTAL)) begin
                        state <= IDLE;
                    end else begin
                        cs    <= 1'b1;
                        odata <= pack_word(12'h000, cnt, BLANK_GLYPH);
                        cnt   <= cnt + 9'd1;
                    end
                end
`ifdef TEXTWR_ROWCLR_EN
                CLR_ROW: begin
                    if (cnt == 9'(COLS)) begin
                        state <= IDLE;
                    end else begin
                        cs    <= 1'b1;
                        odata <= pack_word(12'h000, row_base + cnt, BLANK_GLYPH);
                        cnt   <= cnt + 9'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboarded bench for vga_text_writer: stimulus queues expected writes, a monitor checks them.
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  char_code = 8'h00;
    logic [11:0] char_color = 12'h000;
    logic        clear_req = 1'b0;
    logic        cs;
    logic [31:0] odata;
    logic        busy;
    logic [8:0]  cursor;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t sb[$];

`ifdef TEXTWR_ROWCLR_EN
    localparam int RC = 1;
`else
    localparam int RC = 0;
`endif

    vga_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_code  (char_code),
        .char_color (char_color),
        .clear_req  (clear_req),
        .cs         (cs),
        .odata      (odata),
        .busy       (busy),
        .cursor     (cursor)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input logic [11:0] c, input int idx, input logic [5:0] g);
        logic [8:0] i9;
        i9 = idx[8:0];
        return {c, 3'b000, i9, 2'b00, g};
    endfunction

    task automatic expect_w(input logic [31:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code, input logic [11:0] color);
        int n;
        n = 0;
        char_valid = 1'b1;
        char_code  = code;
        char_color = color;
        @(negedge clk);
        while (!char_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout code %h char_ready %b expected 1", code, char_ready);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
        end
        tick();
        char_valid = 1'b0;
    endtask

    // Monitor: every write strobe outside reset must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cs === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got %h at cycle %0d expected no write", odata, cyc);
                end else begin
                    e = sb.pop_front();
                    if (odata !== e.d || cyc != e.c) begin
                        errors++;
                        $display("FAIL write got %h at cycle %0d expected %h at cycle %0d", odata, cyc, e.d, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first;
        int last;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs", int'(cs), 0);
        chk("rst_odata", int'(odata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(char_ready), 1);
        chk("rst_cursor", int'(cursor), 0);
        tick();

        // 'A' in red at cursor 0
        send(8'h41, 12'hF00);
        expect_w(32'hF000_0021, acc_cyc + 1);
        @(negedge clk);
        chk("a_cursor", int'(cursor), 1);
        tick();

        // clear_req beats a simultaneous byte; byte accepted after the sweep
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_code  = 8'h42;
        char_color = 12'h0F0;
        @(negedge clk);
        chk("clr_ready_low", int'(char_ready), 0);
        n = cyc;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 300; k++) expect_w(word(12'h000, k, 6'd0), n + 1 + k);
        @(negedge clk);
        chk("clr_busy", int'(busy), 1);
        chk("clr_cursor", int'(cursor), 0);
        tick();
        send(8'h42, 12'h0F0);
        chk("clr_accept_cycle", acc_cyc, n + 301);
        expect_w(32'h0F00_0022, acc_cyc + 1);
        @(negedge clk);
        chk("b_cursor", int'(cursor), 1);
        tick();

        // Carriage return
        send(8'h0D, 12'h000);
        @(negedge clk);
        chk("cr_cursor", int'(cursor), 0);
        tick();

        // 20 back-to-back printables fill row 0 and wrap
        first = 0;
        for (int i = 0; i < 20; i++) begin
            send(8'(8'h30 + i), 12'h0AB);
            if (i == 0) first = acc_cyc;
            expect_w(word(12'h0AB, i, 6'(16 + i)), acc_cyc + 1);
        end
        chk("burst_rate", acc_cyc, first + 19);
        last = acc_cyc;
        if (RC == 1) for (int j = 0; j < 20; j++) expect_w(word(12'h000, 20 + j, 6'd0), last + 2 + j);
        @(negedge clk);
        chk("wrap_cursor", int'(cursor), 20);
        tick();
        // Backspace at column 0 writes nothing
        send(8'h08, 12'h000);
        chk("wrap_release", acc_cyc, last + (RC == 1 ? 22 : 2));
        @(negedge clk);
        chk("bs_col0_cursor", int'(cursor), 20);
        tick();

        // Newline from row 1 to row 2
        send(8'h0A, 12'h000);
        n = acc_cyc;
        if (RC == 1) for (int j = 0; j < 20; j++) expect_w(word(12'h000, 40 + j, 6'd0), n + 1 + j);
        @(negedge clk);
        chk("nl_cursor", int'(cursor), 40);
        tick();
        // Unused control code is swallowed
        send(8'h01, 12'hFFF);
        chk("nl_release", acc_cyc, n + (RC == 1 ? 21 : 2));
        @(negedge clk);
        chk("ignored_cursor", int'(cursor), 40);
        tick();

        // Form feed clears, then backspace from cursor 5
        send(8'h0C, 12'h000);
        n = acc_cyc;
        for (int k = 0; k < 300; k++) expect_w(word(12'h000, k, 6'd0), n + 1 + k);
        @(negedge clk);
        chk("ff_cursor", int'(cursor), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h61 + i), 12'hFFF);
            if (i == 0) chk("ff_release", acc_cyc, n + 301);
            expect_w(word(12'hFFF, i, 6'(8'h41 + i)), acc_cyc + 1);
        end
        send(8'h08, 12'h123);
        expect_w(32'h0000_0400, acc_cyc + 1);
        @(negedge clk);
        chk("bs_cursor", int'(cursor), 4);
        tick();
        send(8'h0D, 12'h000);
        send(8'h08, 12'h000);
        @(negedge clk);
        chk("bs_zero_cursor", int'(cursor), 0);
        tick();

        // Walk to row 14, fill it, wrap from 299 to 0
        for (int r = 0; r < 14; r++) begin
            send(8'h0A, 12'h000);
            if (RC == 1) for (int j = 0; j < 20; j++) expect_w(word(12'h000, (r + 1) * 20 + j, 6'd0), acc_cyc + 1 + j);
        end
        @(negedge clk);
        chk("row14_cursor", int'(cursor), 280);
        tick();
        for (int i = 0; i < 20; i++) begin
            send(8'h78, 12'h5A5);
            expect_w(word(12'h5A5, 280 + i, 6'h58), acc_cyc + 1);
        end
        last = acc_cyc;
        if (RC == 1) for (int j = 0; j < 20; j++) expect_w(word(12'h000, j, 6'd0), last + 2 + j);
        @(negedge clk);
        chk("wrap299_cursor", int'(cursor), 0);
        chk("wrap299_ready", int'(char_ready), 1 - RC);
        tick();
        send(8'h0D, 12'h000);
        chk("wrap299_release", acc_cyc, last + (RC == 1 ? 22 : 2));

        // Reset while write 150 of a full clear is on the bus
        clear_req = 1'b1;
        @(negedge clk);
        n = cyc;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 150; k++) expect_w(word(12'h000, k, 6'd0), n + 1 + k);
        repeat (150) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_cs", int'(cs), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_cursor", int'(cursor), 0);
        end
        chk("abort_ready", int'(char_ready), 1);

        repeat (5) tick();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Text-console sequencer for the 20x15 tile VGA display. Accepts a byte stream (character codes plus control codes) over a valid/ready handshake. Tracks a cursor and emits one-cycle `cs` write strobes with packed `odata` words for the tile display's content/colour registers. Also sequences full-screen clears and row blanking on line wrap; it is the only writer of the display's `cs`/`idata` port.

## Interface
- `COLS`, 20, tiles per row
- `ROWS`, 15, tile rows
- `BLANK_GLYPH`, 6'd0, glyph code written by clears/backspace
- `clk`  in  1  system clock (display write clock)
- `rst`  in  1  synchronous, active-high reset
- `char_valid`  in  1  byte available
- `char_ready`  out  1  block accepts byte this cycle
- `char_code`  in  8  byte (printable or control)
- `char_color`  in  12  RGB444 colour for the byte
- `clear_req`  in  1  level request for a full-screen clear
- `cs`  out  1  display write strobe, one cycle per tile write
- `odata`  out  32  write word, valid while `cs`=1
- `busy`  out  1  state != IDLE
- `cursor`  out  9  current tile index, row*COLS+col

## Operation
- Write word: `odata[31:20]` = colour, `[16:8]` = tile index, `[5:0]` = glyph; all other bits 0.
- Clear and blank writes use colour 12'h000.
- States:
  - IDLE: `char_ready`=1 unless `clear_req`=1.
  - CLR_ALL: 300 writes, indices 0..299 ascending.
  - CLR_ROW: COLS writes covering the new cursor row, col 0..COLS-1.
- Priority in IDLE: `clear_req` over `char_valid`. On `clear_req`: enter CLR_ALL, cursor <= 0.
- Byte decode on accept (`char_valid & char_ready`):
  - `0x20..0x7F`: write glyph (code-0x20)[5:0] at cursor with `char_color`, then col+1.
    - If col was COLS-1: col <= 0, row <= (row+1) mod ROWS, enter CLR_ROW.
  - `0x0A`: col <= 0, row advances with wrap, enter CLR_ROW; no glyph write.
  - `0x0D`: col <= 0; no write.
  - `0x08`: if col>0, col-1 and write BLANK_GLYPH at the new position; if col=0, nothing.
  - `0x0C`: same as `clear_req`.
  - Any other code is consumed with no effect.
- Row wrap: row 14 -> row 0, cursor 299 -> 0. No scrolling; the wrapped-into row is blanked.
- Cursor index arithmetic is 9-bit: row*COLS+col, max 299.
- Reset: state IDLE, cursor 0, `cs`=0, `odata`=0, `busy`=0, `char_ready`=1.
- Reset mid-sweep aborts the sweep; no `cs` after the reset cycle.

## Timing
- `cs`/`odata` are registered: a byte accepted at cycle N writes at N+1.
- Wrap or newline accepted at N:
  - glyph write (if any) at N+1;
  - row-clear writes on COLS consecutive cycles starting N+1 (newline) or N+2 (printable);
  - `char_ready` low from N+1 until the cycle after the last row-clear write.
- Full clear accepted at N: writes N+1..N+300; `char_ready` high again at N+301.
- Non-wrapping printables sustain one accept and one write per cycle.
- `clear_req` held high across a finished CLR_ALL triggers another CLR_ALL.
- `cursor` updates at N+1.

## Configuration
- `TEXTWR_ROWCLR_EN`:
  - Defined: wrap or newline enters CLR_ROW as above.
  - Undefined: CLR_ROW does not exist. The cursor moves with no blank writes, and `char_ready` stays high through wraps. Old text in the row remains until overwritten.

## Test plan
- Reset, then 'A' (0x41, colour 12'hF00) -> `cs` at N+1, `odata`=32'hF000_0021, cursor=1.
- 20 printables starting at cursor 0 -> writes at indices 0..19, cursor=20. With the macro, 20 blank writes to indices 20..39 follow, then `char_ready` rises.
- Cursor 299, printable -> write index 299, cursor 0, row clear of indices 0..19. Without the macro: no clear writes, `char_ready` never drops.
- `clear_req` pulse with `char_valid`=1 in the same cycle -> byte not accepted, 300 writes with `odata`=32'h0000_0000..32'h0001_2B00, cursor 0, byte accepted at N+301.
- Cursor 5, 0x08 -> blank write at index 4, cursor 4. Cursor 0, 0x08 -> no `cs`.
- `rst` asserted at write 150 of CLR_ALL -> `cs`=0 from the next cycle, `busy`=0, cursor 0.
